// File: rtl/hop_chain_tester_pkg.sv
// rtl/hop_chain_tester_pkg.sv - FSM states and error codes shared by the hop chain tester.
package hop_tst_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    FLUSH   = 3'd2,
    LAUNCH  = 3'd3,
    MEASURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_FLUSH   = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_LAT     = 3'd3;
  localparam logic [2:0] ERR_XTALK   = 3'd4;
  localparam logic [2:0] ERR_PWIDTH  = 3'd5;

endpackage

// File: rtl/hop_chain_tester_if.sv
// rtl/hop_chain_tester_if.sv - launch/reset/arrival signals between the tester and a hop chain.
interface hop_chain_if #(
  parameter int NUM_RST = 14
);
  logic               start1;
  logic               start2;
  logic [NUM_RST-1:0] rst_chain;
  logic               ff8;
  logic               ff16;

  modport master (
    output start1,
    output start2,
    output rst_chain,
    input  ff8,
    input  ff16
  );

  modport slave (
    input  start1,
    input  start2,
    input  rst_chain,
    output ff8,
    output ff16
  );
endinterface

// File: rtl/hop_arrival_mon.sv
// rtl/hop_arrival_mon.sv - per-chain arrival latch, latency capture and crosstalk flag;
// HOP_PULSE_WIDTH_CHECK_EN adds the post-arrival low-sample check.
module hop_arrival_mon #(
  parameter int LAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             sel,
  input  logic             ff,
  input  logic [LAT_W-1:0] cnt,
  output logic             arrived,
  output logic [LAT_W-1:0] lat_now,
  output logic [LAT_W-1:0] lat,
  output logic             xtalk,
  output logic             pw_err
);

  logic             arrived_q, arrived_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0] cnt_inc;
  logic             hit;

  // Latency is the count this edge produces, saturating at all-ones.
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign hit     = en && sel && ff && !arrived_q;

  always_comb begin
    arrived_d = arrived_q;
    lat_d     = lat_q;
    if (clr) begin
      arrived_d = 1'b0;
      lat_d     = '0;
    end else if (hit) begin
      arrived_d = 1'b1;
      lat_d     = cnt_inc;
    end
  end

`ifdef HOP_PULSE_WIDTH_CHECK_EN
  logic chk_q, chk_d;
  assign chk_d  = hit && !clr;
  assign pw_err = en && chk_q && ff;

  always_ff @(posedge clk) begin
    if (rst) chk_q <= 1'b0;
    else     chk_q <= chk_d;
  end
`else
  assign pw_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      arrived_q <= 1'b0;
      lat_q     <= '0;
    end else begin
      arrived_q <= arrived_d;
      lat_q     <= lat_d;
    end
  end

  assign arrived = arrived_q || hit;
  assign lat_now = hit ? cnt_inc : lat_q;
  assign lat     = lat_q;
  assign xtalk   = en && !sel && ff;

endmodule

// File: rtl/hop_chain_tester.sv
// rtl/hop_chain_tester.sv - hop chain stimulus/checker: reset, flush, launch, latency measure.
// HOP_PULSE_WIDTH_CHECK_EN enables the arrival pulse-width check (err 5).
module hop_chain_tester
  import hop_tst_pkg::*;
#(
  parameter int NUM_RST   = 14,
  parameter int RST_CYC   = 4,
  parameter int FLUSH_CYC = 16,
  parameter int EXP_LAT   = 9,
  parameter int TIMEOUT   = 32,
  parameter int LAT_W     = 8
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic             go,
  input  logic [1:0]       sel,
  hop_chain_if.master      chain,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       err,
  output logic [LAT_W-1:0] lat1,
  output logic [LAT_W-1:0] lat2
);

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [2:0]         err_q, err_d, err_new;
  logic [1:0]         sel_q, sel_d;
  logic               start1_q, start1_d, start2_q, start2_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [NUM_RST-1:0] rst_chain_q, rst_chain_d;
  logic               go_acc, mon_en, all_arr, lat_bad;
  logic               arr1, arr2, xt1, xt2, pw1, pw2;
  logic [LAT_W-1:0]   lat1_now, lat2_now;
`ifdef HOP_PULSE_WIDTH_CHECK_EN
  logic               fin_q, fin_d;
`endif

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign go_acc  = go && (state_q == IDLE || state_q == DONE);
  assign mon_en  = (state_q == LAUNCH || state_q == MEASURE);
  assign all_arr = (arr1 || !sel_q[0]) && (arr2 || !sel_q[1]);
  assign lat_bad = (sel_q[0] && lat1_now != LAT_W'(EXP_LAT)) ||
                   (sel_q[1] && lat2_now != LAT_W'(EXP_LAT));

  hop_arrival_mon #(.LAT_W(LAT_W)) u_mon1 (
    .clk(clock0), .rst(rst1), .clr(go_acc), .en(mon_en), .sel(sel_q[0]),
    .ff(chain.ff8), .cnt(cnt_q), .arrived(arr1), .lat_now(lat1_now),
    .lat(lat1), .xtalk(xt1), .pw_err(pw1)
  );

  hop_arrival_mon #(.LAT_W(LAT_W)) u_mon2 (
    .clk(clock0), .rst(rst1), .clr(go_acc), .en(mon_en), .sel(sel_q[1]),
    .ff(chain.ff16), .cnt(cnt_q), .arrived(arr2), .lat_now(lat2_now),
    .lat(lat2), .xtalk(xt2), .pw_err(pw2)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sel_d   = sel_q;
    err_new = ERR_NONE;
`ifdef HOP_PULSE_WIDTH_CHECK_EN
    fin_d   = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = RESET;
          cnt_d   = '0;
          err_d   = ERR_NONE;
          sel_d   = sel;
        end
      end
      RESET: begin
        if (cnt_q == LAT_W'(RST_CYC - 1)) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FLUSH: begin
        if (chain.ff8 || chain.ff16) begin
          err_d   = ERR_FLUSH;
          state_d = DONE;
        end else if (cnt_q == LAT_W'(FLUSH_CYC - 1)) begin
          state_d = (sel_q == 2'b00) ? DONE : LAUNCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LAUNCH, MEASURE: begin
        cnt_d   = cnt_inc;
        state_d = MEASURE;
        // Ordered so simultaneous errors resolve to the lowest code.
        if (cnt_inc >= LAT_W'(TIMEOUT) && !all_arr) err_new = ERR_TIMEOUT;
        else if (all_arr && lat_bad)                err_new = ERR_LAT;
        else if (xt1 || xt2)                        err_new = ERR_XTALK;
        else if (pw1 || pw2)                        err_new = ERR_PWIDTH;
        if (err_new != ERR_NONE) begin
          err_d   = err_new;
          state_d = DONE;
        end else if (all_arr) begin
`ifdef HOP_PULSE_WIDTH_CHECK_EN
          if (fin_q) state_d = DONE;
          else       fin_d   = 1'b1;
`else
          state_d = DONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    start1_d    = (state_d == LAUNCH) && sel_d[0];
    start2_d    = (state_d == LAUNCH) && sel_d[1];
    rst_chain_d = (state_d == FLUSH || state_d == LAUNCH || state_d == MEASURE) ? '0 : '1;
    busy_d      = (state_d == RESET || state_d == FLUSH || state_d == LAUNCH || state_d == MEASURE);
    done_d      = (state_d == DONE);
    pass_d      = done_d && (err_d == ERR_NONE);
  end

  always_ff @(posedge clock0) begin
    if (rst1) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= ERR_NONE;
      sel_q       <= 2'b00;
      start1_q    <= 1'b0;
      start2_q    <= 1'b0;
      rst_chain_q <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      sel_q       <= sel_d;
      start1_q    <= start1_d;
      start2_q    <= start2_d;
      rst_chain_q <= rst_chain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

`ifdef HOP_PULSE_WIDTH_CHECK_EN
  always_ff @(posedge clock0) begin
    if (rst1) fin_q <= 1'b0;
    else      fin_q <= fin_d;
  end
`endif

  assign chain.start1    = start1_q;
  assign chain.start2    = start2_q;
  assign chain.rst_chain = rst_chain_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err             = err_q;

endmodule
